// File: rtl/knn_master_pkg.sv
// rtl/knn_master_pkg.sv - state codes and default register map for the KNN native-bus master
package knn_master_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic [2:0] S_EN   = 3'd0;
    localparam logic [2:0] S_IDLE = 3'd1;
    localparam logic [2:0] S_WX   = 3'd2;
    localparam logic [2:0] S_WY   = 3'd3;
    localparam logic [2:0] S_WL   = 3'd4;
    localparam logic [2:0] S_RD   = 3'd5;
    localparam logic [2:0] S_OUT  = 3'd6;

    localparam int X_ADDR_DEF      = 0;
    localparam int Y_ADDR_DEF      = 1;
    localparam int LABEL_ADDR_DEF  = 2;
    localparam int DIST_ADDR_DEF   = 3;
    localparam int ENABLE_ADDR_DEF = 4;

    localparam logic [DATA_W_DEF/8-1:0] WSTRB_ALL = {(DATA_W_DEF/8){1'b1}};

endpackage

// File: rtl/knn_nat_master_if.sv
// rtl/knn_nat_master_if.sv - command/result streams and native bus of the KNN master
interface knn_nat_master_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_x;
    logic [DATA_W-1:0] cmd_y;
    logic [DATA_W-1:0] cmd_label;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_dist;
    logic [DATA_W-1:0] res_label;

    logic                m_valid;
    logic [ADDR_W-1:0]   m_address;
    logic [DATA_W-1:0]   m_wdata;
    logic [DATA_W/8-1:0] m_wstrb;
    logic [DATA_W-1:0]   m_rdata;
    logic                m_ready;

    modport master (
        input  cmd_valid, cmd_x, cmd_y, cmd_label, res_ready, m_rdata, m_ready,
        output cmd_ready, res_valid, res_dist, res_label,
               m_valid, m_address, m_wdata, m_wstrb
    );

    modport slave (
        output cmd_valid, cmd_x, cmd_y, cmd_label, res_ready, m_rdata, m_ready,
        input  cmd_ready, res_valid, res_dist, res_label,
               m_valid, m_address, m_wdata, m_wstrb
    );
endinterface

// File: rtl/knn_nat_xfer.sv
// rtl/knn_nat_xfer.sv - single native-bus transaction engine; watchdog under KNN_MASTER_TIMEOUT_EN
module knn_nat_xfer #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                write,
    output logic                done,
    output logic [DATA_W-1:0]   rdata,
    output logic                timed_out,
    output logic                m_valid,
    output logic [ADDR_W-1:0]   m_address,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ready
);

    logic                m_valid_q, m_valid_d;
    logic [ADDR_W-1:0]   m_address_q, m_address_d;
    logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
    logic [DATA_W/8-1:0] m_wstrb_q, m_wstrb_d;
    logic                ack;
    logic                expire;

    assign ack = m_valid_q & m_ready;

`ifdef KNN_MASTER_TIMEOUT_EN
    logic [15:0] wd_q, wd_d;

    assign expire = m_valid_q & ~m_ready & (wd_q == 16'(TIMEOUT - 1));

    always_comb begin
        wd_d = wd_q + 16'd1;
        if (!m_valid_q || m_ready || expire) begin
            wd_d = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= 16'd0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign expire = 1'b0;
`endif

    assign done      = ack | expire;
    assign timed_out = expire;
    assign rdata     = expire ? {DATA_W{1'b1}} : m_rdata;

    // A request is only launched while m_valid is low, so every ack is
    // followed by at least one idle cycle before the next request.
    always_comb begin
        m_valid_d   = m_valid_q;
        m_address_d = m_address_q;
        m_wdata_d   = m_wdata_q;
        m_wstrb_d   = m_wstrb_q;
        if (!m_valid_q && start) begin
            m_valid_d   = 1'b1;
            m_address_d = addr;
            m_wdata_d   = write ? wdata : '0;
            m_wstrb_d   = write ? {(DATA_W/8){1'b1}} : '0;
        end else if (done) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q   <= 1'b0;
            m_address_q <= '0;
            m_wdata_q   <= '0;
            m_wstrb_q   <= '0;
        end else begin
            m_valid_q   <= m_valid_d;
            m_address_q <= m_address_d;
            m_wdata_q   <= m_wdata_d;
            m_wstrb_q   <= m_wstrb_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_address = m_address_q;
    assign m_wdata   = m_wdata_q;
    assign m_wstrb   = m_wstrb_q;

endmodule

// File: rtl/knn_nat_master.sv
// rtl/knn_nat_master.sv - streams (x, y, label) points into the KNN slave and returns (distance, label)
// Optional watchdog: KNN_MASTER_TIMEOUT_EN (error stays 0 when undefined).
module knn_nat_master
    import knn_master_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int X_ADDR      = X_ADDR_DEF,
    parameter int Y_ADDR      = Y_ADDR_DEF,
    parameter int LABEL_ADDR  = LABEL_ADDR_DEF,
    parameter int DIST_ADDR   = DIST_ADDR_DEF,
    parameter int ENABLE_ADDR = ENABLE_ADDR_DEF,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              rst,
    knn_nat_master_if.master  bus,
    output logic              busy,
    output logic [15:0]       count,
    output logic              error
);

    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] x_q, x_d, y_q, y_d, lbl_q, lbl_d;
    logic [DATA_W-1:0] dist_q, dist_d, rlbl_q, rlbl_d;
    logic [15:0]       count_q, count_d;
    logic              error_q, error_d;

    logic              start, write, done, timed_out;
    logic [ADDR_W-1:0] x_addr;
    logic [DATA_W-1:0] x_wdata, x_rdata;

    always_comb begin
        start   = 1'b1;
        write   = 1'b1;
        x_addr  = '0;
        x_wdata = '0;
        case (state_q)
            S_EN: begin
                x_addr  = ADDR_W'(ENABLE_ADDR);
                x_wdata = DATA_W'(1);
            end
            S_WX: begin
                x_addr  = ADDR_W'(X_ADDR);
                x_wdata = x_q;
            end
            S_WY: begin
                x_addr  = ADDR_W'(Y_ADDR);
                x_wdata = y_q;
            end
            S_WL: begin
                x_addr  = ADDR_W'(LABEL_ADDR);
                x_wdata = lbl_q;
            end
            S_RD: begin
                x_addr = ADDR_W'(DIST_ADDR);
                write  = 1'b0;
            end
            default: start = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        lbl_d   = lbl_q;
        dist_d  = dist_q;
        rlbl_d  = rlbl_q;
        count_d = count_q;
        error_d = error_q | timed_out;
        case (state_q)
            S_EN:   if (done) state_d = S_IDLE;
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    x_d     = bus.cmd_x;
                    y_d     = bus.cmd_y;
                    lbl_d   = bus.cmd_label;
                    state_d = S_WX;
                end
            end
            S_WX:   if (done) state_d = S_WY;
            S_WY:   if (done) state_d = S_WL;
            S_WL:   if (done) state_d = S_RD;
            S_RD: begin
                if (done) begin
                    dist_d  = x_rdata;
                    rlbl_d  = lbl_q;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (bus.res_ready) begin
                    count_d = count_q + 16'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_EN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EN;
            x_q     <= '0;
            y_q     <= '0;
            lbl_q   <= '0;
            dist_q  <= '0;
            rlbl_q  <= '0;
            count_q <= 16'd0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            lbl_q   <= lbl_d;
            dist_q  <= dist_d;
            rlbl_q  <= rlbl_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    knn_nat_xfer #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) u_xfer (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .addr      (x_addr),
        .wdata     (x_wdata),
        .write     (write),
        .done      (done),
        .rdata     (x_rdata),
        .timed_out (timed_out),
        .m_valid   (bus.m_valid),
        .m_address (bus.m_address),
        .m_wdata   (bus.m_wdata),
        .m_wstrb   (bus.m_wstrb),
        .m_rdata   (bus.m_rdata),
        .m_ready   (bus.m_ready)
    );

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.res_valid = (state_q == S_OUT);
    assign bus.res_dist  = dist_q;
    assign bus.res_label = rlbl_q;
    assign busy          = (state_q != S_IDLE);
    assign count         = count_q;
    assign error         = error_q;

endmodule

// File: tb/tb_knn_nat_master.sv
// tb/tb_knn_nat_master.sv - directed self-checking bench for knn_nat_master
module tb_knn_nat_master;

    logic        clk;
    logic        rst;
    logic        busy;
    logic [15:0] count;
    logic        error;

    int          checks = 0;
    int          errors = 0;

    int          lat = 1;
    bit          noack_rd = 1'b0;
    int          wcnt = 0;
    logic [31:0] dist_val = 32'h2A;

    logic [40:0] log_q[$];
    bit          unstable = 1'b0;
    logic        pv = 1'b0, pa = 1'b0;
    logic [4:0]  pad = '0;
    logic [31:0] pwd = '0;
    logic [3:0]  pst = '0;

    logic [11:0] mv, rv;
    bit          bp_bad;
    int          n;

    localparam logic [40:0] LOG_EN = {4'hF, 5'd4, 32'd1};

    knn_nat_master_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    knn_nat_master dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus.master),
        .busy  (busy),
        .count (count),
        .error (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-ready slave: ack arrives 'lat' cycles after valid is seen.
    always @(posedge clk) begin
        if (rst) begin
            bus.m_ready <= 1'b0;
            wcnt        <= 0;
        end else if (bus.m_valid && !bus.m_ready && !(noack_rd && bus.m_wstrb == 4'h0)) begin
            if (wcnt + 1 >= lat) begin
                bus.m_ready <= 1'b1;
                wcnt        <= 0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            bus.m_ready <= 1'b0;
            if (!bus.m_valid) wcnt <= 0;
        end
    end

    assign bus.m_rdata = (bus.m_address == 5'd3) ? dist_val : 32'h0;

    always @(negedge clk) begin
        if (bus.m_valid && bus.m_ready)
            log_q.push_back({bus.m_wstrb, bus.m_address,
                             (bus.m_wstrb != 4'h0) ? bus.m_wdata : bus.m_rdata});
        if (bus.m_valid && pv && !pa &&
            (bus.m_address != pad || bus.m_wdata != pwd || bus.m_wstrb != pst))
            unstable = 1'b1;
        pv  = bus.m_valid;
        pa  = bus.m_valid && bus.m_ready;
        pad = bus.m_address;
        pwd = bus.m_wdata;
        pst = bus.m_wstrb;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [31:0] x, input logic [31:0] y, input logic [31:0] l);
        bus.cmd_x     = x;
        bus.cmd_y     = y;
        bus.cmd_label = l;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !bus.cmd_ready; i++) @(negedge clk);
        chk("cmd_accept", bus.cmd_ready, 1'b1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_res(input string tag);
        for (int i = 0; i < 600 && !bus.res_valid; i++) @(negedge clk);
        chk(tag, bus.res_valid, 1'b1);
    endtask

    task automatic res_handshake();
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_x     = '0;
        bus.cmd_y     = '0;
        bus.cmd_label = '0;
        bus.res_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_m_valid", bus.m_valid, 1'b0);
        chk("rst_m_address", bus.m_address, 5'd0);
        chk("rst_m_wstrb", bus.m_wstrb, 4'h0);
        chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
        chk("rst_res_valid", bus.res_valid, 1'b0);
        chk("rst_res_dist", bus.res_dist, 32'h0);
        chk("rst_count", count, 16'h0);
        chk("rst_error", error, 1'b0);

        rst = 1'b0;
        for (int i = 0; i < 20 && !bus.cmd_ready; i++) @(negedge clk);
        chk("en_cmd_ready", bus.cmd_ready, 1'b1);
        chk("en_busy", busy, 1'b0);
        chk("en_log_n", log_q.size(), 1);
        chk("en_log0", log_q[0], LOG_EN);
        log_q.delete();

        // Exact zero-wait timeline; cmd inputs are scrambled after acceptance.
        bus.cmd_x     = 32'd3;
        bus.cmd_y     = 32'd7;
        bus.cmd_label = 32'd5;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_x     = 32'hAAAA;
        bus.cmd_y     = 32'hBBBB;
        bus.cmd_label = 32'hCCCC;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            mv[c-1] = bus.m_valid;
            rv[c-1] = bus.res_valid;
        end
        chk("lat_m_valid", mv, 12'h6DB);
        chk("lat_res_valid", rv, 12'h800);
        chk("pt1_dist", bus.res_dist, 32'h2A);
        chk("pt1_label", bus.res_label, 32'd5);
        chk("pt1_log_n", log_q.size(), 4);
        chk("pt1_log0", log_q[0], {4'hF, 5'd0, 32'd3});
        chk("pt1_log1", log_q[1], {4'hF, 5'd1, 32'd7});
        chk("pt1_log2", log_q[2], {4'hF, 5'd2, 32'd5});
        chk("pt1_log3", log_q[3], {4'h0, 5'd3, 32'h2A});
        res_handshake();
        chk("pt1_count", count, 16'd1);
        chk("pt1_idle", bus.cmd_ready, 1'b1);

        // Result backpressure with a second command waiting.
        dist_val = 32'h55;
        send_cmd(32'd10, 32'd20, 32'd9);
        wait_res("bp_res");
        bus.cmd_x     = 32'd1;
        bus.cmd_y     = 32'd2;
        bus.cmd_label = 32'd3;
        bus.cmd_valid = 1'b1;
        bp_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!(bus.res_valid && bus.res_dist == 32'h55 && bus.res_label == 32'd9 && !bus.cmd_ready))
                bp_bad = 1'b1;
        end
        chk("bp_hold", bp_bad, 1'b0);
        res_handshake();
        chk("bp_count", count, 16'd2);
        chk("bp_ready_after", bus.cmd_ready, 1'b1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("bp_accept_busy", busy, 1'b1);
        chk("bp_accept_ready", bus.cmd_ready, 1'b0);
        wait_res("bp_res2");
        chk("bp_label2", bus.res_label, 32'd3);
        res_handshake();
        chk("bp_count2", count, 16'd3);

        // Slow slave: requests must hold steady and appear once each.
        lat = 3;
        dist_val = 32'h1234;
        log_q.delete();
        send_cmd(32'hDEAD, 32'hBEEF, 32'h11);
        wait_res("slow_res");
        chk("slow_dist", bus.res_dist, 32'h1234);
        chk("slow_log_n", log_q.size(), 4);
        chk("slow_log0", log_q[0], {4'hF, 5'd0, 32'hDEAD});
        chk("slow_log1", log_q[1], {4'hF, 5'd1, 32'hBEEF});
        chk("slow_log2", log_q[2], {4'hF, 5'd2, 32'h11});
        chk("slow_log3", log_q[3], {4'h0, 5'd3, 32'h1234});
        chk("slow_stable", unstable, 1'b0);
        res_handshake();
        chk("slow_count", count, 16'd4);

        // Reset while the Y write is outstanding.
        lat = 1;
        send_cmd(32'd1, 32'd2, 32'd3);
        for (int i = 0; i < 40 && !(bus.m_valid && bus.m_address == 5'd1); i++) @(negedge clk);
        chk("rwy_reach", bus.m_valid && bus.m_address == 5'd1, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("rwy_m_valid", bus.m_valid, 1'b0);
        chk("rwy_count", count, 16'd0);
        chk("rwy_cmd_ready", bus.cmd_ready, 1'b0);
        rst = 1'b0;
        log_q.delete();
        for (int i = 0; i < 20 && !bus.cmd_ready; i++) @(negedge clk);
        chk("rwy_idle", bus.cmd_ready, 1'b1);
        chk("rwy_log_n", log_q.size(), 1);
        chk("rwy_log0", log_q[0], LOG_EN);

`ifdef KNN_MASTER_TIMEOUT_EN
        noack_rd = 1'b1;
        send_cmd(32'd4, 32'd5, 32'd6);
        for (int i = 0; i < 60 && !(bus.m_valid && bus.m_wstrb == 4'h0); i++) @(negedge clk);
        n = 0;
        while (bus.m_valid && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk("to_len", n, 255);
        chk("to_error", error, 1'b1);
        wait_res("to_res");
        chk("to_dist", bus.res_dist, 32'hFFFF_FFFF);
        chk("to_label", bus.res_label, 32'd6);
        res_handshake();
        noack_rd = 1'b0;
`else
        chk("no_to_error", error, 1'b0);
`endif

        chk("final_stable", unstable, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
